// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS retire-trace dumper: controller states and record kinds.
package mips_trace_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CAPTURE     = 3'd1,
        DUMP_TRACE  = 3'd2,
        DUMP_REGS   = 3'd3,
        DUMP_MEM    = 3'd4,
        DONE        = 3'd5
    } state_e;

    localparam logic [1:0] KIND_TRACE = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_MEM   = 2'd2;

endpackage

// File: rtl/mips_trace_ram.sv
// Trace buffer: one synchronous write port, one combinational read port.
module mips_trace_ram
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mips_trace_dump.sv
// Captures a window of retired instructions, then streams trace, register-file
// and data-memory records through a single registered valid/ready stage.
module mips_trace_dump
    import mips_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TRACE_DEPTH = 32,
    parameter int N_REGS      = 32,
    parameter int MEM_WORDS   = 256,
    parameter int CAPTURE_N   = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         retire,
    input  logic [ADDR_W-1:0]            pc_in,
    input  logic [DATA_W-1:0]            instr_in,
    output logic [$clog2(N_REGS)-1:0]    reg_rd_addr,
    input  logic [DATA_W-1:0]            reg_rd_data,
    output logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]            mem_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_kind,
    output logic [15:0]                  out_index,
    output logic [ADDR_W-1:0]            out_a,
    output logic [DATA_W-1:0]            out_b,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int TW      = $clog2(TRACE_DEPTH);
    localparam int RAW     = $clog2(N_REGS);
    localparam int MAW     = $clog2(MEM_WORDS);
    localparam int TRACE_N = (CAPTURE_N < TRACE_DEPTH) ? CAPTURE_N : TRACE_DEPTH;

    localparam logic [15:0] CAP_LAST   = 16'(CAPTURE_N - 1);
    localparam logic [15:0] DEPTH_L    = 16'(TRACE_DEPTH);
    localparam logic [15:0] TRACE_LAST = 16'(TRACE_N - 1);
    localparam logic [15:0] REGS_LAST  = 16'(N_REGS - 1);
    localparam logic [15:0] MEM_END    = 16'(MEM_WORDS);

    state_e                     state_r;
    logic [TW-1:0]              wr_ptr_r;
    logic [15:0]                ret_cnt_r;
    logic [15:0]                rd_idx_r;
    logic                       overflow_r;
    logic                       busy_r;
    logic                       done_r;

    logic                       out_valid_r;
    logic [1:0]                 out_kind_r;
    logic [15:0]                out_index_r;
    logic [ADDR_W-1:0]          out_a_r;
    logic [DATA_W-1:0]          out_b_r;

    logic                       wr_en_s;
    logic [TW-1:0]              rd_ptr_s;
    logic [ADDR_W+DATA_W-1:0]   rd_entry_s;
    logic                       slot_free_s;
    logic                       load_s;
    logic [1:0]                 ld_kind_s;
    logic [ADDR_W-1:0]          ld_a_s;
    logic [DATA_W-1:0]          ld_b_s;

    assign wr_en_s     = (state_r == CAPTURE) && retire;
    // After a wrap the oldest surviving entry sits at the write pointer
    assign rd_ptr_s    = (overflow_r ? wr_ptr_r : {TW{1'b0}}) + rd_idx_r[TW-1:0];
    assign slot_free_s = !out_valid_r || out_ready;

    mips_trace_ram #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_r),
        .wdata ({pc_in, instr_in}),
        .raddr (rd_ptr_s),
        .rdata (rd_entry_s)
    );

    // Select the record that would be loaded this cycle
    always_comb begin
        load_s    = 1'b0;
        ld_kind_s = KIND_TRACE;
        ld_a_s    = {ADDR_W{1'b0}};
        ld_b_s    = {DATA_W{1'b0}};
        case (state_r)
            DUMP_TRACE: begin
                load_s = slot_free_s;
                ld_a_s = rd_entry_s[ADDR_W+DATA_W-1:DATA_W];
                ld_b_s = rd_entry_s[DATA_W-1:0];
            end
            DUMP_REGS: begin
                load_s    = slot_free_s;
                ld_kind_s = KIND_REG;
                ld_b_s    = reg_rd_data;
            end
            DUMP_MEM: begin
                load_s    = slot_free_s && (rd_idx_r != MEM_END);
                ld_kind_s = KIND_MEM;
                ld_b_s    = mem_rd_data;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Controller: capture bookkeeping and dump sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            wr_ptr_r   <= {TW{1'b0}};
            ret_cnt_r  <= 16'd0;
            rd_idx_r   <= 16'd0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r    <= CAPTURE;
                        wr_ptr_r   <= {TW{1'b0}};
                        ret_cnt_r  <= 16'd0;
                        rd_idx_r   <= 16'd0;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (retire) begin
                        wr_ptr_r  <= wr_ptr_r + TW'(1'b1);
                        ret_cnt_r <= ret_cnt_r + 16'd1;
                        if (ret_cnt_r >= DEPTH_L) begin
                            overflow_r <= 1'b1;
                        end
                        if (ret_cnt_r == CAP_LAST) begin
                            state_r <= DUMP_TRACE;
                        end
                    end
                end
                DUMP_TRACE: begin
                    if (load_s) begin
                        if (rd_idx_r == TRACE_LAST) begin
                            state_r  <= DUMP_REGS;
                            rd_idx_r <= 16'd0;
                        end else begin
                            rd_idx_r <= rd_idx_r + 16'd1;
                        end
                    end
                end
                DUMP_REGS: begin
                    if (load_s) begin
                        if (rd_idx_r == REGS_LAST) begin
                            state_r  <= DUMP_MEM;
                            rd_idx_r <= 16'd0;
                        end else begin
                            rd_idx_r <= rd_idx_r + 16'd1;
                        end
                    end
                end
                DUMP_MEM: begin
                    // rd_idx == MEM_END means every record is loaded; wait for the last accept
                    if (load_s) begin
                        rd_idx_r <= rd_idx_r + 16'd1;
                    end else if ((rd_idx_r == MEM_END) && out_valid_r && out_ready) begin
                        state_r  <= DONE;
                        rd_idx_r <= 16'd0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: loads whenever the slot is free, otherwise holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_kind_r  <= 2'd0;
            out_index_r <= 16'd0;
            out_a_r     <= {ADDR_W{1'b0}};
            out_b_r     <= {DATA_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_kind_r  <= ld_kind_s;
            out_index_r <= rd_idx_r;
            out_a_r     <= ld_a_s;
            out_b_r     <= ld_b_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign reg_rd_addr = rd_idx_r[RAW-1:0];
    assign mem_rd_addr = rd_idx_r[MAW-1:0];
    assign out_valid   = out_valid_r;
    assign out_kind    = out_kind_r;
    assign out_index   = out_index_r;
    assign out_a       = out_a_r;
    assign out_b       = out_b_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_mips_trace_dump.sv
// Directed-plus-random bench: a default-parameter DUT and a small wrapping DUT,
// both checked against a list-based model of what the dump must contain.
module tb_mips_trace_dump;

    localparam int NREG = 32;
    localparam int NMEM = 256;
    localparam int CAPN = 20;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, retire, out_ready;
    logic [31:0] pc_in, instr_in, reg_rd_data, mem_rd_data;
    logic [4:0]  reg_rd_addr;
    logic [7:0]  mem_rd_addr;
    logic        out_valid, busy, done, overflow;
    logic [1:0]  out_kind;
    logic [15:0] out_index;
    logic [31:0] out_a, out_b;

    logic        o_start, o_retire, o_ready, o_valid, o_busy, o_done, o_overflow;
    logic [31:0] o_pc, o_instr, o_reg_data, o_mem_data, o_a, o_b;
    logic [1:0]  o_reg_addr, o_mem_addr, o_kind;
    logic [15:0] o_index;

    logic [31:0] regs [NREG];
    logic [31:0] dmem [NMEM];
    logic [31:0] o_ins [40];

    assign reg_rd_data = regs[reg_rd_addr];
    assign mem_rd_data = dmem[mem_rd_addr];
    assign o_reg_data  = regs[o_reg_addr];
    assign o_mem_data  = dmem[o_mem_addr];

    mips_trace_dump dut (
        .clk(clk), .reset(reset), .start(start), .retire(retire),
        .pc_in(pc_in), .instr_in(instr_in),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_index(out_index), .out_a(out_a), .out_b(out_b),
        .busy(busy), .done(done), .overflow(overflow)
    );

    mips_trace_dump #(
        .TRACE_DEPTH(32), .N_REGS(4), .MEM_WORDS(4), .CAPTURE_N(40)
    ) u_ovf (
        .clk(clk), .reset(reset), .start(o_start), .retire(o_retire),
        .pc_in(o_pc), .instr_in(o_instr),
        .reg_rd_addr(o_reg_addr), .reg_rd_data(o_reg_data),
        .mem_rd_addr(o_mem_addr), .mem_rd_data(o_mem_data),
        .out_valid(o_valid), .out_ready(o_ready), .out_kind(o_kind),
        .out_index(o_index), .out_a(o_a), .out_b(o_b),
        .busy(o_busy), .done(o_done), .overflow(o_overflow)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [81:0] exp_q [$];
    logic [31:0] cap_pc [$];
    logic [31:0] cap_in [$];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_data();
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        for (int i = 0; i < NMEM; i++) dmem[i] = $urandom;
    endtask

    // Random retire gaps; only the first CAPN retires after start belong in the trace
    task automatic capture(input bit retire_with_start, input bit start_mid);
        int k;
        cap_pc.delete();
        cap_in.delete();
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; retire = retire_with_start;
        pc_in = 32'hDEAD_0000; instr_in = $urandom;
        @(negedge clk);
        start = 1'b0; retire = 1'b0;
        check("busy_in_capture", busy, 1);
        check("done_in_capture", done, 0);
        k = 0;
        while (k < CAPN + 3) begin
            retire   = ($urandom_range(0, 3) != 0);
            start    = start_mid && (k == 5) && retire;
            pc_in    = 32'(4 * k);
            instr_in = $urandom;
            if (retire) begin
                if (k < CAPN) begin
                    cap_pc.push_back(pc_in);
                    cap_in.push_back(instr_in);
                end
                k++;
            end
            @(negedge clk);
            start = 1'b0;
        end
        retire = 1'b0;
        check("overflow_clear", overflow, 0);
        check("busy_after_capture", busy, 1);
    endtask

    task automatic build_expected();
        int m, first;
        exp_q.delete();
        m = (CAPN < DEPTH) ? CAPN : DEPTH;
        first = cap_pc.size() - m;
        for (int i = 0; i < m; i++)
            exp_q.push_back({2'd0, 16'(i), cap_pc[first + i], cap_in[first + i]});
        for (int i = 0; i < NREG; i++) exp_q.push_back({2'd1, 16'(i), 32'd0, regs[i]});
        for (int i = 0; i < NMEM; i++) exp_q.push_back({2'd2, 16'(i), 32'd0, dmem[i]});
    endtask

    // mode 0: always ready, 1: toggling ready, 2: random ready
    task automatic drain(input int mode, input bit abort_in_regs, output bit aborted);
        int budget, n_acc;
        bit stalled;
        logic [81:0] held, cur, e;
        budget = 0; n_acc = 0; stalled = 1'b0; aborted = 1'b0; held = '0;
        while (exp_q.size() > 0 && budget < 4000 && !aborted) begin
            @(negedge clk);
            budget++;
            cur = {out_kind, out_index, out_a, out_b};
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_fields", cur, held);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (budget % 2) == 1;
                default: out_ready = $urandom_range(0, 1) == 1;
            endcase
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_acc++;
                check("record", cur, e);
                if (abort_in_regs && e[81:80] == 2'd1 && e[79:64] == 16'd5) aborted = 1'b1;
            end
            stalled = out_valid && !out_ready;
            held = cur;
        end
        if (!aborted) begin
            check("records_remaining", exp_q.size(), 0);
            check("record_count", n_acc, 308);
            @(negedge clk);
            check("done_high", done, 1);
            check("busy_low", busy, 0);
            check("valid_low_after_done", out_valid, 0);
        end
    endtask

    initial begin
        bit ab;
        int budget;
        logic [81:0] e;
        reset = 1'b0; start = 1'b0; retire = 1'b0; out_ready = 1'b0;
        pc_in = 32'd0; instr_in = 32'd0;
        o_start = 1'b0; o_retire = 1'b0; o_ready = 1'b1; o_pc = 32'd0; o_instr = 32'd0;
        fill_data();
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_flags", {busy, done, overflow}, 0);
        check("rst_fields", {out_kind, out_index, out_a, out_b}, 0);
        check("rst_addrs", {reg_rd_addr, mem_rd_addr}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Plain run, continuous ready
        capture(1'b0, 1'b0);
        build_expected();
        drain(0, 1'b0, ab);

        // Toggling ready, start pulsed mid-capture must be ignored
        fill_data();
        capture(1'b0, 1'b1);
        build_expected();
        drain(1, 1'b0, ab);

        // Retire coinciding with start is not captured; random ready
        fill_data();
        capture(1'b1, 1'b0);
        build_expected();
        drain(2, 1'b0, ab);

        // Reset during the register phase aborts immediately
        fill_data();
        capture(1'b0, 1'b0);
        build_expected();
        drain(0, 1'b1, ab);
        check("abort_reached", ab, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_record", out_valid, 0);
        fill_data();
        capture(1'b0, 1'b0);
        build_expected();
        drain(0, 1'b0, ab);

        // Wrapping configuration: 40 retires into 32 entries
        @(negedge clk);
        o_start = 1'b1;
        @(negedge clk);
        o_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            o_retire = 1'b1; o_pc = 32'(4 * k); o_instr = $urandom; o_ins[k] = o_instr;
            @(negedge clk);
        end
        o_retire = 1'b0;
        check("ovf_flag", o_overflow, 1);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({2'd0, 16'(i), 32'(4 * (i + 8)), o_ins[i + 8]});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 16'(i), 32'd0, regs[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 16'(i), 32'd0, dmem[i]});
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            if (o_valid) begin
                e = exp_q.pop_front();
                check("ovf_record", {o_kind, o_index, o_a, o_b}, e);
            end
            @(negedge clk);
            budget++;
        end
        check("ovf_remaining", exp_q.size(), 0);
        check("ovf_done", o_done, 1);
        check("ovf_overflow_kept", o_overflow, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_trace_dump.md
MIPS_TRACE_DUMP -- requirements
Module: mips_trace_dump

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, instruction/register/memory word width
- ADDR_W, 32, PC width
- TRACE_DEPTH, 32, trace buffer entries (power of 2, >=2)
- N_REGS, 32, register-file entries to dump
- MEM_WORDS, 256, data-memory words to dump
- CAPTURE_N, 20, retired instructions to capture per run (>=1)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-low reset
- start, in, 1, arm a capture run (pulse)
- retire, in, 1, an instruction completes this cycle
- pc_in, in, ADDR_W, PC of the retiring instruction
- instr_in, in, DATA_W, retiring instruction word
- reg_rd_addr, out, clog2(N_REGS), register-file read address
- reg_rd_data, in, DATA_W, combinational register read data
- mem_rd_addr, out, clog2(MEM_WORDS), data-memory read address
- mem_rd_data, in, DATA_W, combinational memory read data
- out_valid, out, 1, output record valid
- out_ready, in, 1, consumer accepts record
- out_kind, out, 2, record type: 0 trace, 1 register, 2 memory
- out_index, out, 16, entry index within kind
- out_a, out, ADDR_W, trace: PC; otherwise 0
- out_b, out, DATA_W, trace: instruction; otherwise value
- busy, out, 1, high in every state except IDLE and DONE
- done, out, 1, high in DONE
- overflow, out, 1, oldest trace entries were overwritten

Function
REQ-003 The FSM SHALL have states IDLE, CAPTURE, DUMP_TRACE, DUMP_REGS, DUMP_MEM and DONE.
REQ-004 start in IDLE or DONE SHALL clear counters and overflow and enter CAPTURE next cycle; start in any other state SHALL be ignored.
REQ-005 A retire in the same cycle as an accepted start SHALL NOT be captured.
REQ-006 In CAPTURE, each retire SHALL write {pc_in, instr_in} at wr_ptr, increment wr_ptr mod TRACE_DEPTH and increment the retire count.
REQ-007 The retire that brings the count to CAPTURE_N SHALL be captured, and the FSM SHALL enter DUMP_TRACE next cycle; retire SHALL be ignored outside CAPTURE.
REQ-008 If CAPTURE_N > TRACE_DEPTH, overflow SHALL be set on the first overwrite.
REQ-009 DUMP_TRACE SHALL emit min(CAPTURE_N, TRACE_DEPTH) records oldest-first:
- overflow=0: start at entry 0
- overflow=1: start at wr_ptr
- out_index: 0 upward
REQ-010 DUMP_REGS SHALL emit N_REGS records (index i = reg_rd_addr i); DUMP_MEM SHALL then emit MEM_WORDS records likewise; the FSM SHALL then enter DONE.
REQ-011 Output SHALL be a single registered stage; a record SHALL load when (!out_valid || out_ready) and records remain, giving one record per cycle under continuous ready.
REQ-012 While out_valid && !out_ready, all out_* fields SHALL hold stable.
REQ-013 reg_rd_addr/mem_rd_addr SHALL present the address being loaded in the load cycle; read data SHALL be sampled in that same cycle.
REQ-014 The last record of a phase SHALL be followed without a bubble by the first record of the next phase.
REQ-015 DONE SHALL be entered only after the final record is accepted; done SHALL stay high until the next start.

Reset
REQ-016 On reset low, asynchronously: state=IDLE; out_valid, busy, done, overflow, all counters and pointers = 0; out_kind/out_index/out_a/out_b and read addresses = 0.
REQ-017 Reset mid-run SHALL abort without any further record; trace storage need not be cleared.

Structure
REQ-018 Package mips_trace_pkg SHALL hold the state enum and the out_kind constants (KIND_TRACE=0, KIND_REG=1, KIND_MEM=2).
REQ-019 Trace storage SHALL be sub-module mips_trace_ram: TRACE_DEPTH x (ADDR_W+DATA_W), one synchronous write port, one combinational read port.

Verification
REQ-020 start, then 20 retires with pc 0x0,0x4,...,0x4C, out_ready=1 -> 20 trace records, index 0..19, out_a as given, overflow=0; then 32 register and 256 memory records; done=1.
REQ-021 CAPTURE_N=40, TRACE_DEPTH=32, pc = 4*k -> overflow=1; 32 trace records with out_a 0x20..0x9C.
REQ-022 out_ready toggling 1/0 every cycle -> no record lost or duplicated; fields stable while stalled; total 308 records.
REQ-023 start and retire in the same cycle, then 20 more retires -> the first retire absent from the trace.
REQ-024 reset low during DUMP_REGS -> out_valid=0 and busy=0 immediately; a new start after release gives a full, correct run.
REQ-025 start pulsed during CAPTURE -> ignored; the retire count does not restart.
